sram_1r1w_lanes: RTL and testbench
==================================

// Module: sram_1r1w_lanes
// PURPOSE
//  Parametrised single-clock 1R1W SRAM behavioural model. Successor to the fixed 32x144 two-port macro models.
//  Adds per-lane write masking, selectable read-during-write semantics, out-of-range detection and a
//  post-reset clear engine. Instantiated by generated memory wrappers for caches and queues.
// PARAMETERS
//  WIDTH          144  data word width in bits; must be a multiple of LANE_W
//  DEPTH          32   number of words; need not be a power of two
//  ADDR_W         5    address width; must satisfy 2**ADDR_W >= DEPTH
//  LANE_W         8    write-mask granularity in bits; NLANE = WIDTH/LANE_W
//  WRITE_FIRST    1    1: same-address read returns new data; 0: returns old data
//  CLEAR_ON_RESET 1    1: zero every word after reset; 0: no clear, contents undefined (X)
// PORTS
//  CE     in   1        clock; all state changes on posedge
//  RST    in   1        asynchronous reset, active-high
//  CSB1   in   1        read select, active-low
//  A1     in   ADDR_W   read address
//  O1     out  WIDTH    registered read data
//  O1V    out  1        O1 updated this cycle (read completed)
//  CSB2   in   1        write select, active-low
//  WEB2   in   1        write enable, active-low; write when CSB2=0 and WEB2=0
//  A2     in   ADDR_W   write address
//  I2     in   WIDTH    write data
//  BWE2   in   NLANE    per-lane write enable, active-high; bit g covers I2[g*LANE_W +: LANE_W]
//  BUSY   out  1        clear engine running; all port requests are ignored while high
//  AERR   out  1        one-cycle pulse: an accepted read or write used an address >= DEPTH
// BEHAVIOUR
//  Reset (RST=1, async): O1=0, O1V=0, AERR=0, clr_addr=0.
//    CLEAR_ON_RESET=1: state=CLEAR, BUSY=1. CLEAR_ON_RESET=0: state=READY, BUSY=0.
//  FSM states are CLEAR and READY.
//    CLEAR: each posedge writes 0 to mem[clr_addr], then increments clr_addr.
//      The posedge that writes DEPTH-1 moves the FSM to READY; BUSY falls at that edge.
//      The clear takes exactly DEPTH cycles after RST deasserts.
//    CLEAR: CSB1/CSB2 are ignored, not queued. O1V=0, O1 holds, AERR=0.
//    READY: terminal until the next reset. Reset during CLEAR restarts the clear at address 0.
//  Read (READY, CSB1=0 at posedge):
//    O1 <= mem[A1] at that edge (latency 1); O1V=1 for the following cycle.
//    CSB1=1: O1 holds its last value and O1V=0.
//  Write (READY, CSB2=0, WEB2=0):
//    Only lanes with BWE2[g]=1 are updated. BWE2=0 performs no write and raises no error.
//  Same edge, A1==A2, both accepted:
//    WRITE_FIRST=1: O1 = new data in enabled lanes, old data in the other lanes.
//    WRITE_FIRST=0: O1 = the full old word.
//  Address >= DEPTH:
//    A write is dropped; memory is unchanged.
//    A read completes with O1=0 and O1V=1.
//    AERR=1 in the following cycle; AERR is set if either port is out of range.
//  CSB2=0 with WEB2=1 is a no-op.
//  Reads never modify memory. Writes never change O1 except via the same-address rule above.
//  No X on O1 for any in-range read after a clear.
// TESTING
//  1 Reset/clear, DEPTH=32: pulse RST, count cycles -> BUSY high exactly 32 cycles; a read of each of addr 0..31 after BUSY=0 gives O1=0, O1V=1.
//  2 Write/read: write A2=5, I2=144'hA5.., BWE2=all-1; read A1=5 next cycle -> O1=the written word, one cycle after the read edge.
//  3 Lane mask: mem[3]=all-1s; write 0 to mem[3] with BWE2=18'h00001; read 3 -> O1=144'hFF..FF00.
//  4 Collision on addr 7 (old=0, new=all-1s, BWE2=18'h3):
//    WRITE_FIRST=1 -> O1=16'hFFFF in the low lanes, 0 elsewhere; WRITE_FIRST=0 -> O1=0.
//  5 DEPTH=20, ADDR_W=5: write addr 25, then read addr 25 -> AERR pulses after each, O1=0; mem[0..19] unchanged.
//  6 Reset mid-clear: assert RST at clr_addr=10 -> after release, BUSY stays high for DEPTH full cycles; requests issued while BUSY produce no O1V and no writes.

Source files
------------

// File: rtl/sram_1r1w_lanes.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sram_1r1w_lanes                                                  |
// | Brief    : parametrised 1R1W SRAM model with lane masks and a reset clear   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module sram_1r1w_lanes #(
  parameter int WIDTH          = 144,
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 5,
  parameter int LANE_W         = 8,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NLANE         = WIDTH / LANE_W
) (
  input  logic              CE,
  input  logic              RST,
  input  logic              CSB1,
  input  logic [ADDR_W-1:0] A1,
  output logic [WIDTH-1:0]  O1,
  output logic              O1V,
  input  logic              CSB2,
  input  logic              WEB2,
  input  logic [ADDR_W-1:0] A2,
  input  logic [WIDTH-1:0]  I2,
  input  logic [NLANE-1:0]  BWE2,
  output logic              BUSY,
  output logic              AERR
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] c_last      = ADDR_W'(DEPTH - 1);
  localparam state_t            c_rst_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [WIDTH-1:0]  mem [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;

  logic              w_ready;
  logic              w_rd_acc;
  logic              w_rd_ok;
  logic              w_wr_acc;
  logic              w_wr_ok;
  logic              w_wr_en;
  logic              w_bypass;
  logic [WIDTH-1:0]  w_rdword;
  logic [WIDTH-1:0]  w_old2;
  logic [WIDTH-1:0]  w_wdata;

  always_ff @(posedge CE or posedge RST) begin
    if (RST) begin
      r_state <= c_rst_state;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The edge that clears the last word also hands the array over to the ports.
  always_comb begin
    w_state_nxt = r_state;
    BUSY        = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        BUSY = 1'b1;
        if (r_clr_addr == c_last) begin
          w_state_nxt = ST_READY;
        end
      end
      default: begin
        w_state_nxt = ST_READY;
      end
    endcase
  end

  assign w_ready  = (r_state == ST_READY);
  assign w_rd_acc = w_ready & ~CSB1;
  assign w_rd_ok  = (A1 <= c_last);
  assign w_wr_acc = w_ready & ~CSB2 & ~WEB2 & (|BWE2);
  assign w_wr_ok  = (A2 <= c_last);
  assign w_wr_en  = w_wr_acc & w_wr_ok;

  assign w_rdword = mem[A1];
  assign w_old2   = mem[A2];

  // Full word as it will look after the write: enabled lanes new, the rest old.
  generate
    for (genvar g = 0; g < NLANE; g++) begin : g_lane
      assign w_wdata[g*LANE_W +: LANE_W] = BWE2[g] ? I2[g*LANE_W +: LANE_W]
                                                   : w_old2[g*LANE_W +: LANE_W];
    end
  endgenerate

  assign w_bypass = (WRITE_FIRST != 0) && w_wr_en && (A1 == A2);

  always_ff @(posedge CE or posedge RST) begin
    if (RST) begin
      O1         <= '0;
      O1V        <= 1'b0;
      AERR       <= 1'b0;
      r_clr_addr <= '0;
    end else begin
      O1V  <= w_rd_acc;
      AERR <= (w_rd_acc & ~w_rd_ok) | (w_wr_acc & ~w_wr_ok);
      if (w_rd_acc) begin
        if (!w_rd_ok) begin
          O1 <= '0;
        end else if (w_bypass) begin
          O1 <= w_wdata;
        end else begin
          O1 <= w_rdword;
        end
      end
      if (r_state == ST_CLEAR) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  // Storage has no reset; the clear engine owns it until READY.
  always_ff @(posedge CE) begin
    if (!RST) begin
      if (r_state == ST_CLEAR) begin
        mem[r_clr_addr] <= '0;
      end else if (w_wr_en) begin
        mem[A2] <= w_wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_lanes.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_sram_1r1w_lanes                                               |
// | Brief    : scoreboard bench over three configurations of sram_1r1w_lanes    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_sram_1r1w_lanes;

  localparam logic [143:0] c_ones = {144{1'b1}};
  localparam logic [143:0] c_a5   = {18{8'hA5}};
  localparam logic [143:0] c_mask = {{136{1'b1}}, 8'h00};
  localparam logic [143:0] c_ffff = 144'hFFFF;

  logic         CE = 1'b0;
  logic         RST;
  logic         CSB1, CSB2, WEB2;
  logic [4:0]   A1, A2;
  logic [143:0] I2;
  logic [17:0]  BWE2;

  logic [143:0] o1_a, o1_b, o1_c;
  logic         o1v_a, o1v_b, o1v_c;
  logic         busy_a, busy_b, busy_c;
  logic         aerr_a, aerr_b, aerr_c;

  int vectors     = 0;
  int miscompares = 0;

  logic [143:0] q_a[$];
  logic [143:0] q_b[$];
  logic [143:0] q_c[$];

  always #5 CE = ~CE;

  // a: write-first, 32 deep; b: read-first, 32 deep; c: write-first, 20 deep
  sram_1r1w_lanes #(.WIDTH(144), .DEPTH(32), .ADDR_W(5), .LANE_W(8), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut_a (
    .CE(CE), .RST(RST), .CSB1(CSB1), .A1(A1), .O1(o1_a), .O1V(o1v_a), .CSB2(CSB2), .WEB2(WEB2),
    .A2(A2), .I2(I2), .BWE2(BWE2), .BUSY(busy_a), .AERR(aerr_a));
  sram_1r1w_lanes #(.WIDTH(144), .DEPTH(32), .ADDR_W(5), .LANE_W(8), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut_b (
    .CE(CE), .RST(RST), .CSB1(CSB1), .A1(A1), .O1(o1_b), .O1V(o1v_b), .CSB2(CSB2), .WEB2(WEB2),
    .A2(A2), .I2(I2), .BWE2(BWE2), .BUSY(busy_b), .AERR(aerr_b));
  sram_1r1w_lanes #(.WIDTH(144), .DEPTH(20), .ADDR_W(5), .LANE_W(8), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut_c (
    .CE(CE), .RST(RST), .CSB1(CSB1), .A1(A1), .O1(o1_c), .O1V(o1v_c), .CSB2(CSB2), .WEB2(WEB2),
    .A2(A2), .I2(I2), .BWE2(BWE2), .BUSY(busy_c), .AERR(aerr_c));

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CE) begin
    if (o1v_a) begin
      if (q_a.size() == 0) chk("unexpected_o1v_a", 144'd1, 144'd0);
      else chk("o1_a", o1_a, q_a.pop_front());
    end
    if (o1v_b) begin
      if (q_b.size() == 0) chk("unexpected_o1v_b", 144'd1, 144'd0);
      else chk("o1_b", o1_b, q_b.pop_front());
    end
    if (o1v_c) begin
      if (q_c.size() == 0) chk("unexpected_o1v_c", 144'd1, 144'd0);
      else chk("o1_c", o1_c, q_c.pop_front());
    end
  end

  task automatic op(input bit rd, input logic [4:0] a1, input bit wr, input logic [4:0] a2,
                    input logic [143:0] d, input logic [17:0] bwe,
                    input logic [143:0] ea, input logic [143:0] eb, input logic [143:0] ec);
    @(negedge CE);
    CSB1 = ~rd;
    A1   = a1;
    CSB2 = ~wr;
    WEB2 = ~wr;
    A2   = a2;
    I2   = d;
    BWE2 = bwe;
    if (rd) begin
      q_a.push_back(ea);
      q_b.push_back(eb);
      q_c.push_back(ec);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [143:0] ea, input logic [143:0] eb,
                    input logic [143:0] ec);
    op(1'b1, a, 1'b0, 5'd0, '0, '0, ea, eb, ec);
  endtask

  task automatic wr(input logic [4:0] a, input logic [143:0] d, input logic [17:0] bwe);
    op(1'b0, 5'd0, 1'b1, a, d, bwe, '0, '0, '0);
  endtask

  task automatic idle();
    op(1'b0, 5'd0, 1'b0, 5'd0, '0, '0, '0, '0, '0);
  endtask

  // Counts edges after release until each BUSY falls; optionally drops held requests when c finishes.
  task automatic count_busy(input bit drop_on_c, output int na, output int nb, output int nc);
    na = 0; nb = 0; nc = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge CE);
      #1;
      if (na == 0 && !busy_a) na = cyc;
      if (nb == 0 && !busy_b) nb = cyc;
      if (nc == 0 && !busy_c) begin
        nc = cyc;
        if (drop_on_c) begin
          CSB1 = 1'b1;
          CSB2 = 1'b1;
          WEB2 = 1'b1;
        end
      end
      if (na != 0 && nb != 0 && nc != 0) break;
    end
  endtask

  function automatic logic [143:0] exp_after(input int a);
    case (a)
      3:       return c_mask;
      5:       return c_a5;
      7:       return c_ffff;
      default: return '0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int na, nb, nc;
    RST = 1'b1; CSB1 = 1'b1; CSB2 = 1'b1; WEB2 = 1'b1;
    A1 = '0; A2 = '0; I2 = '0; BWE2 = '0;
    repeat (2) @(posedge CE);
    @(negedge CE);
    chk("rst_o1", o1_a, '0);
    chk("rst_o1v", {143'd0, o1v_a}, '0);
    chk("rst_aerr", {143'd0, aerr_c}, '0);
    chk("rst_busy", {142'd0, busy_a, busy_c}, 144'd3);
    RST = 1'b0;

    // reset clear length, then every word reads back zero
    count_busy(1'b0, na, nb, nc);
    chk("clear_cycles_a", 144'(na), 144'd32);
    chk("clear_cycles_b", 144'(nb), 144'd32);
    chk("clear_cycles_c", 144'(nc), 144'd20);
    for (int i = 0; i < 32; i++) rd(5'(i), '0, '0, '0);
    idle();

    // full write then read back
    wr(5'd5, c_a5, 18'h3FFFF);
    rd(5'd5, c_a5, c_a5, c_a5);

    // single-lane mask
    wr(5'd3, c_ones, 18'h3FFFF);
    wr(5'd3, '0, 18'h00001);
    rd(5'd3, c_mask, c_mask, c_mask);

    // same-address collision: write-first vs read-first
    op(1'b1, 5'd7, 1'b1, 5'd7, c_ones, 18'h00003, c_ffff, '0, c_ffff);
    rd(5'd7, c_ffff, c_ffff, c_ffff);

    // out-of-range on the 20-deep instance only
    wr(5'd25, c_ones, 18'h3FFFF);
    rd(5'd25, c_ones, c_ones, '0);
    chk("aerr_wr_c", {143'd0, aerr_c}, 144'd1);
    chk("aerr_wr_a", {143'd0, aerr_a}, 144'd0);
    idle();
    chk("aerr_rd_c", {143'd0, aerr_c}, 144'd1);
    chk("aerr_rd_b", {143'd0, aerr_b}, 144'd0);
    idle();
    chk("aerr_clr_c", {143'd0, aerr_c}, 144'd0);
    for (int i = 0; i < 20; i++) rd(5'(i), exp_after(i), exp_after(i), exp_after(i));
    idle();

    // reset mid-clear with requests held while busy
    @(negedge CE);
    RST = 1'b1;
    @(negedge CE);
    RST = 1'b0;
    repeat (10) @(posedge CE);
    @(negedge CE);
    RST = 1'b1;
    #1;
    chk("midrst_busy", {143'd0, busy_a}, 144'd1);
    chk("midrst_o1", o1_a, '0);
    @(negedge CE);
    RST = 1'b0;
    CSB1 = 1'b0; A1 = 5'd3;
    CSB2 = 1'b0; WEB2 = 1'b0; A2 = 5'd3; I2 = c_ones; BWE2 = 18'h3FFFF;
    count_busy(1'b1, na, nb, nc);
    chk("reclear_cycles_a", 144'(na), 144'd32);
    chk("reclear_cycles_b", 144'(nb), 144'd32);
    chk("reclear_cycles_c", 144'(nc), 144'd20);
    rd(5'd3, '0, '0, '0);
    rd(5'd7, '0, '0, '0);
    repeat (3) idle();
    chk("queue_left_a", 144'(q_a.size()), '0);
    chk("queue_left_b", 144'(q_b.size()), '0);
    chk("queue_left_c", 144'(q_c.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
